// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-master arbiter and refresh scheduler in front of the SDRAM Control sequencer.
// Optional feature: define SDRAM_ARB_REFRESH_EN to build the refresh timer, REFRESH state, ref_req and ref_overrun.
module sdram_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int REFRESH_PERIOD = 780
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [2:0]        burst0,
    input  logic [2:0]        burst1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    input  logic              ctl_idle,
    output logic              ctl_write,
    output logic              ctl_biwen,
    output logic              ctl_biren,
    output logic [2:0]        ctl_burst,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic              ref_req,
    input  logic              ref_ack,
    output logic              ref_overrun
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
`ifdef SDRAM_ARB_REFRESH_EN
        , REFRESH
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                sel_q, sel_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                ctl_write_q, ctl_write_d;
    logic [2:0]          ctl_burst_q, ctl_burst_d;
    logic [ADDR_W-1:0]   ctl_addr_q, ctl_addr_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                biwen_q, biwen_d, biren_q, biren_d;
    logic                win;

    // requester 1 wins when it is alone, or when both ask and 0 was served last
    assign win = req1 & (~req0 | ~last_q);

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int TW = $clog2(REFRESH_PERIOD);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_PERIOD - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          ref_req_q, ref_req_d;
    logic          overrun_q, overrun_d;
    logic          expire, ack_take;

    // free-running refresh timer; an expiry re-arms pending even on the edge an ack clears it
    always_comb begin
        expire    = tmr_q == '0;
        ack_take  = (state_q == REFRESH) && ref_ack;
        tmr_d     = expire ? RELOAD : tmr_q - TW'(1);
        pend_d    = expire | (pend_q & ~ack_take);
        overrun_d = overrun_q | (expire & pend_q & ~ack_take);
    end

    // refresh timer and flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_q     <= RELOAD;
            pend_q    <= 1'b0;
            ref_req_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            pend_q    <= pend_d;
            ref_req_q <= ref_req_d;
            overrun_q <= overrun_d;
        end
    end

    assign ref_req     = ref_req_q;
    assign ref_overrun = overrun_q;
`else
    logic unused_ref_ack;
    assign unused_ref_ack = ref_ack;
    assign ref_req        = 1'b0;
    assign ref_overrun    = 1'b0;
`endif

    // next-state and registered-output logic of the transfer sequencer
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        ctl_write_d = ctl_write_q;
        ctl_burst_d = ctl_burst_q;
        ctl_addr_d  = ctl_addr_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        biwen_d     = 1'b0;
        biren_d     = 1'b0;
`ifdef SDRAM_ARB_REFRESH_EN
        ref_req_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
                if (pend_q) begin
                    state_d   = REFRESH;
                    ref_req_d = 1'b1;
                end else
`endif
                if (req0 || req1) begin
                    sel_d       = win;
                    last_d      = win;
                    ctl_write_d = win ? wr1 : wr0;
                    ctl_burst_d = win ? burst1 : burst0;
                    ctl_addr_d  = win ? addr1 : addr0;
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                biwen_d = ctl_write_q;
                biren_d = ~ctl_write_q;
                cnt_d   = 3'd0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!ctl_idle)
                    state_d = WAIT_DONE;
                else if (cnt_q == 3'd7)
                    state_d = ISSUE;
                else
                    cnt_d = cnt_q + 3'd1;
            end
            WAIT_DONE: begin
                if (ctl_idle) begin
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    state_d = IDLE;
                end
            end
`ifdef SDRAM_ARB_REFRESH_EN
            REFRESH: begin
                ref_req_d = ~ref_ack;
                state_d   = ref_ack ? IDLE : REFRESH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // sequencer registers; reset abandons any in-flight transfer without a done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            cnt_q       <= 3'd0;
            ctl_write_q <= 1'b0;
            ctl_burst_q <= 3'd0;
            ctl_addr_q  <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            biwen_q     <= 1'b0;
            biren_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            ctl_write_q <= ctl_write_d;
            ctl_burst_q <= ctl_burst_d;
            ctl_addr_q  <= ctl_addr_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            biwen_q     <= biwen_d;
            biren_q     <= biren_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign ctl_write = ctl_write_q;
    assign ctl_burst = ctl_burst_q;
    assign ctl_addr  = ctl_addr_q;
    assign ctl_biwen = biwen_q;
    assign ctl_biren = biren_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter with a timing-rule transfer model and a refresh instance.
module tb_sdram_arbiter;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0, req1, wr0, wr1;
    logic [2:0]    burst0, burst1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, done0, done1;
    logic          ctl_idle, ctl_write, ctl_biwen, ctl_biren;
    logic [2:0]    ctl_burst;
    logic [AW-1:0] ctl_addr;
    logic          ref_req, ref_overrun;

    logic          rreq0, r_ack;
    logic          r_gnt0, r_gnt1, r_done0, r_done1, r_write, r_biwen, r_biren, r_req, r_ovr;
    logic [2:0]    r_burst;
    logic [AW-1:0] r_addr;

    sdram_arbiter #(.ADDR_W(AW), .REFRESH_PERIOD(60000)) u_arb (
        .clock(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .burst0(burst0), .burst1(burst1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .ctl_idle(ctl_idle), .ctl_write(ctl_write), .ctl_biwen(ctl_biwen), .ctl_biren(ctl_biren),
        .ctl_burst(ctl_burst), .ctl_addr(ctl_addr),
        .ref_req(ref_req), .ref_ack(1'b0), .ref_overrun(ref_overrun)
    );

    sdram_arbiter #(.ADDR_W(AW), .REFRESH_PERIOD(20)) u_ref (
        .clock(clk), .reset(reset),
        .req0(rreq0), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
        .burst0(3'd0), .burst1(3'd0), .addr0(16'h0000), .addr1(16'h0000),
        .gnt0(r_gnt0), .gnt1(r_gnt1), .done0(r_done0), .done1(r_done1),
        .ctl_idle(1'b1), .ctl_write(r_write), .ctl_biwen(r_biwen), .ctl_biren(r_biren),
        .ctl_burst(r_burst), .ctl_addr(r_addr),
        .ref_req(r_req), .ref_ack(r_ack), .ref_overrun(r_ovr)
    );

    int   errs, checks, cyc;
    int   b_start, b_end, c_d, c_len, c_ign;
    bit   p0, p1, m_last;
    logic f_wr [2];
    logic [2:0] f_b [2];
    logic [AW-1:0] f_a [2];

    typedef struct {
        bit n0, n1;
        logic wr;
        logic [2:0] b;
        logic [AW-1:0] a;
        int d, len, ign;
        bit exp_w;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive;
        req0 = p0; req1 = p1;
        wr0 = f_wr[0]; wr1 = f_wr[1];
        burst0 = f_b[0]; burst1 = f_b[1];
        addr0 = f_a[0]; addr1 = f_a[1];
    endtask

    // one cycle: move to the next falling edge and run the controller model
    task automatic step;
        @(negedge clk);
        cyc++;
        if (ctl_biwen || ctl_biren) begin
            if (c_ign > 0) c_ign--;
            else begin
                b_start = cyc + c_d;
                b_end   = b_start + c_len;
            end
        end
        ctl_idle = !(cyc >= b_start && cyc < b_end);
    endtask

    // one transfer from an idle arbiter; expected event times come from the timing rules:
    // grant at +1, start pulse at +2 (+9 per ignored pulse), done one cycle after the controller returns idle
    task automatic run_txn(input bit n0, input bit n1, input logic wr, input logic [2:0] b,
                           input logic [AW-1:0] a, input int d, input int len, input int ign, input bit exp_w);
        int p, n;
        if (n0 && !p0) begin p0 = 1; f_wr[0] = wr;  f_b[0] = b;  f_a[0] = a;  end
        if (n1 && !p1) begin p1 = 1; f_wr[1] = ~wr; f_b[1] = ~b; f_a[1] = ~a; end
        drive();
        c_d = d; c_len = len; c_ign = ign;
        p = 2 + 9 * ign;
        n = p + d + len + 1;
        for (int k = 1; k <= n; k++) begin
            step();
            chk("gnt0", gnt0, k == 1 && !exp_w);
            chk("gnt1", gnt1, k == 1 && exp_w);
            chk("biwen", ctl_biwen, k >= 2 && k <= p && (k - 2) % 9 == 0 && f_wr[exp_w]);
            chk("biren", ctl_biren, k >= 2 && k <= p && (k - 2) % 9 == 0 && !f_wr[exp_w]);
            chk("done0", done0, k == n && !exp_w);
            chk("done1", done1, k == n && exp_w);
            if (k == 2) begin
                chk("ctl_write", ctl_write, f_wr[exp_w]);
                chkv("ctl_burst", 16'(ctl_burst), 16'(f_b[exp_w]));
                chkv("ctl_addr", ctl_addr, f_a[exp_w]);
            end
            if (k == 1) begin
                if (exp_w) p1 = 0; else p0 = 0;
                drive();
            end
        end
        m_last = exp_w;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bit n0, n1, q0, q1, w;
        errs = 0; checks = 0; cyc = 0;
        b_start = 0; b_end = 0; c_d = 2; c_len = 1; c_ign = 0;
        p0 = 0; p1 = 0; m_last = 1;
        for (int i = 0; i < 2; i++) begin f_wr[i] = 0; f_b[i] = 0; f_a[i] = 0; end
        drive();
        ctl_idle = 1'b1; rreq0 = 1'b0; r_ack = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // reset state
        step();
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_biwen", ctl_biwen, 1'b0);
        chk("rst_biren", ctl_biren, 1'b0);
        chk("rst_write", ctl_write, 1'b0);
        chkv("rst_burst", 16'(ctl_burst), 16'h0);
        chkv("rst_addr", ctl_addr, 16'h0);
        chk("rst_ref_req", ref_req, 1'b0);
        chk("rst_overrun", ref_overrun, 1'b0);

        // directed transfers: first write, alternating grants, a retried read, delay boundaries
        tbl[0] = '{1, 0, 1'b1, 3'b011, 16'h1234, 2, 10, 0, 0};
        tbl[1] = '{1, 1, 1'b0, 3'b001, 16'h0100, 1, 3,  0, 1};
        tbl[2] = '{0, 1, 1'b1, 3'b010, 16'h0200, 3, 2,  0, 0};
        tbl[3] = '{1, 0, 1'b0, 3'b100, 16'h0300, 2, 4,  0, 1};
        tbl[4] = '{0, 1, 1'b1, 3'b101, 16'h0400, 1, 1,  0, 0};
        tbl[5] = '{0, 0, 1'b0, 3'b000, 16'h0000, 2, 5,  1, 1};
        tbl[6] = '{0, 1, 1'b0, 3'b110, 16'hA5A5, 7, 1,  0, 1};
        tbl[7] = '{1, 0, 1'b1, 3'b111, 16'hFFFF, 1, 1,  0, 0};
        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].n0, tbl[i].n1, tbl[i].wr, tbl[i].b, tbl[i].a,
                    tbl[i].d, tbl[i].len, tbl[i].ign, tbl[i].exp_w);

        // asynchronous reset while the controller is busy
        p1 = 1; f_wr[1] = 1'b1; f_b[1] = 3'd5; f_a[1] = 16'hBEEF;
        drive();
        c_d = 2; c_len = 10; c_ign = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin p1 = 0; drive(); end
        end
        chk("pre_rst_write", ctl_write, 1'b1);
        chkv("pre_rst_addr", ctl_addr, 16'hBEEF);
        #2 reset = 1'b1;
        #1;
        chk("async_write", ctl_write, 1'b0);
        chkv("async_addr", ctl_addr, 16'h0);
        chkv("async_burst", 16'(ctl_burst), 16'h0);
        chk("async_gnt1", gnt1, 1'b0);
        chk("async_biwen", ctl_biwen, 1'b0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("no_done0", done0, 1'b0);
            chk("no_done1", done1, 1'b0);
        end
        m_last = 1;
        run_txn(1, 1, 1'b1, 3'd2, 16'h0042, 3, 2, 0, 0);
        run_txn(0, 0, 1'b0, 3'd0, 16'h0000, 1, 2, 0, 1);

        // randomized transfers against the round-robin model
        for (int i = 0; i < 40; i++) begin
            n0 = 1'($urandom_range(0, 1));
            n1 = 1'($urandom_range(0, 1));
            if (!p0 && !p1 && !n0 && !n1) n0 = 1;
            q0 = p0 | n0;
            q1 = p1 | n1;
            w  = (q0 && q1) ? !m_last : q1;
            run_txn(n0, n1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    $urandom_range(1, 7), $urandom_range(1, 12), ($urandom_range(0, 4) == 0) ? 1 : 0, w);
        end

`ifdef SDRAM_ARB_REFRESH_EN
        // period 20, ack three cycles after each request
        do_reset();
        for (int t = 1; t <= 70; t++) begin
            step();
            chk("ref_req_periodic", r_req, t >= 21 && (t - 21) % 20 < 4);
            chk("ref_ovr_periodic", r_ovr, 1'b0);
            r_ack = (t >= 21 && (t - 21) % 20 == 3);
        end
        r_ack = 1'b0;
        // ack withheld 25 cycles: the second expiry finds refresh still pending
        do_reset();
        for (int t = 1; t <= 70; t++) begin
            step();
            chk("ref_req_late", r_req, (t >= 21 && t < 47) || t >= 61);
            chk("ref_ovr_late", r_ovr, t >= 40);
            r_ack = (t == 46);
        end
        r_ack = 1'b0;
        // pending refresh beats a request raised at the same time
        do_reset();
        for (int t = 1; t <= 23; t++) begin
            step();
            if (t == 21) begin
                chk("prio_ref_req", r_req, 1'b1);
                chk("prio_gnt_held", r_gnt0, 1'b0);
            end
            if (t == 22) begin
                chk("prio_ref_drop", r_req, 1'b0);
                chk("prio_gnt_wait", r_gnt0, 1'b0);
            end
            if (t == 23) chk("prio_gnt_after", r_gnt0, 1'b1);
            if (t == 20) rreq0 = 1'b1;
            r_ack = (t == 21);
        end
        rreq0 = 1'b0;
        r_ack = 1'b0;
`else
        // refresh compiled out: outputs tied low, requests granted directly
        do_reset();
        for (int t = 1; t <= 40; t++) begin
            step();
            chk("noref_req", r_req, 1'b0);
            chk("noref_ovr", r_ovr, 1'b0);
            if (t == 21) chk("noref_gnt", r_gnt0, 1'b1);
            if (t == 20) rreq0 = 1'b1;
            if (t == 21) rreq0 = 1'b0;
            r_ack = (t % 3 == 0);
        end
        r_ack = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
